// File: rtl/logicnet_lut_layer_seq.sv
// Time-multiplexed LogicNet layer: NEURONS truth-table neurons share one
// runtime-loadable LUT RAM and are evaluated one neuron per cycle.
// Ports: clk, rst (async, active-high);
//   s_valid/s_ready/s_data : input word stream;
//   m_valid/m_ready/m_data : output word stream;
//   cfg_we/cfg_addr/cfg_data : table write port, cfg_busy when ignored;
//   eval_cnt : saturating count of output transfers.
// Optional macro LOGICNET_LUT_CNT_EN enables the eval_cnt counter;
// without it eval_cnt is tied to zero.
module logicnet_lut_layer_seq #(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 2,
  parameter int NEURONS  = 4,
  localparam int IDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NEURONS*IN_BITS-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NEURONS*OUT_BITS-1:0]  m_data,
  input  logic                         cfg_we,
  input  logic [IDX_W+IN_BITS-1:0]     cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data,
  output logic                         cfg_busy,
  output logic [15:0]                  eval_cnt
);

  localparam int DEPTH = 2 ** (IDX_W + IN_BITS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NEURONS - 1);
  localparam logic [IDX_W:0] NLIM = (IDX_W + 1)'(NEURONS);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t state_q, state_d;

  logic [NEURONS*IN_BITS-1:0] din_q;
  logic [IDX_W-1:0]           idx_q;
  logic [IN_BITS-1:0]         ent;
  logic [OUT_BITS-1:0]        rd;
  logic [IDX_W-1:0]           cidx;
  logic                       cfg_ok;

  // Distributed LUT RAM; deliberately not reset so tables survive rst.
  logic [OUT_BITS-1:0] mem [DEPTH];

  assign cidx   = cfg_addr[IDX_W+IN_BITS-1 -: IDX_W];
  assign cfg_ok = cfg_we && (state_q == IDLE)
               && ({1'b0, cidx} < NLIM);

  always_ff @(posedge clk) begin
    if (cfg_ok) mem[cfg_addr] <= cfg_data;
  end

  // Combinational read of the current neuron's entry.
  assign ent = din_q[idx_q*IN_BITS +: IN_BITS];
  assign rd  = mem[{idx_q, ent}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    cfg_busy = 1'b1;
    unique case (state_q)
      IDLE: begin
        s_ready  = 1'b1;
        cfg_busy = 1'b0;
        if (s_valid) state_d = EVAL;
      end
      EVAL: begin
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q  <= '0;
      idx_q  <= '0;
      m_data <= '0;
    end else begin
      if (state_q == IDLE && s_valid) begin
        din_q <= s_data;
        idx_q <= '0;
      end
      if (state_q == EVAL) begin
        m_data[idx_q*OUT_BITS +: OUT_BITS] <= rd;
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

`ifdef LOGICNET_LUT_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (m_valid && m_ready && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign eval_cnt = cnt_q;
`else
  assign eval_cnt = 16'h0000;
`endif

endmodule
